sysid_read_master: RTL and testbench
====================================

# sysid_read_master

Avalon-MM read master that runs at power-up (and on demand) to read the two 32-bit words of the system ID peripheral. Word 0 is the ID and word 1 is the build timestamp. It compares both words against expected values and reports pass/fail and timeout flags. It sits on the system interconnect next to the Nios II CPU as a hardware self-check. Software and board LEDs can confirm that the loaded FPGA image matches the expected Qsys build without running code.

## Interface
Parameters:
- EXPECTED_ID, 0: expected value of word 0.
- EXPECTED_TIMESTAMP, 1582963486: expected value of word 1.
- TIMEOUT_CYCLES, 255: per-transaction cycle limit. Legal range 1..65535.
- AUTO_START, 1: when 1, one check sequence launches automatically after reset release.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  request a check sequence. Sampled only in IDLE or DONE.
- avm_address  out  1  word address: 0 = ID, 1 = timestamp.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall. A request is accepted on an edge where avm_read=1 and avm_waitrequest=0.
- avm_readdatavalid  in  1  read data valid.
- avm_readdata  in  32  read data.
- busy  out  1  sequence in progress.
- done  out  1  sequence finished. Level signal, held until the next start.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP.
- timeout  out  1  the sequence was aborted by the timeout.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

## Operation
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- Reset state:
  - AUTO_START=1: first state after reset is ID_REQ (the first edge after reset release enters ID_REQ).
  - AUTO_START=0: first state after reset is IDLE.
- IDLE/DONE + start=1 → ID_REQ. Entering ID_REQ clears done, id_ok, ts_ok, timeout, id_value and ts_value.
- start while busy=1 is ignored.
- ID_REQ:
  - Outputs: avm_read=1, avm_address=0.
  - Address is held stable while avm_waitrequest=1.
  - On accept → ID_WAIT.
- ID_WAIT:
  - avm_read=0.
  - On avm_readdatavalid=1: capture avm_readdata into id_value → TS_REQ.
- TS_REQ / TS_WAIT: identical handshake with avm_address=1. Data is captured into ts_value, then → DONE.
- Read data is never sampled in a REQ state. Data valid is honored only in WAIT states, i.e. no earlier than the edge after acceptance.
- DONE:
  - done=1.
  - id_ok = (id_value == EXPECTED_ID) and ts_ok = (ts_value == EXPECTED_TIMESTAMP). Both are full 32-bit compares.
  - If timeout=1, then id_ok=0 and ts_ok=0.
- Timeout:
  - A 16-bit counter is cleared on entry to each REQ state.
  - It increments every cycle spent in that REQ state or the WAIT state that follows.
  - If the count reaches TIMEOUT_CYCLES-1 and the completing event (accept in REQ, data valid in WAIT) is absent on that edge: avm_read drops, timeout=1, state → DONE.
  - A completing event on the limit edge wins over the timeout.
- avm_readdatavalid arriving in IDLE or DONE (a stray beat after an abort) is ignored. Captured values are unchanged.
- busy=1 exactly in the REQ and WAIT states.

## Timing
- All outputs are decoded from registered state and registers. There are no combinational input-to-output paths.
- Reset values:
  - avm_read=0, avm_address=0.
  - busy=0, done=0, id_ok=0, ts_ok=0, timeout=0.
  - id_value=0, ts_value=0.
- Best case: 0 wait states and data valid one cycle after accept. Edges after the start-sampling edge:
  - E1: ID_REQ entered.
  - E2: ID accepted.
  - E3: ID captured.
  - E4: TS accepted.
  - E5: TS captured, done=1.
- Each waitrequest cycle adds one cycle. Each cycle of extra read latency adds one cycle.
- Reset asserted mid-sequence: all outputs return to their reset values immediately (asynchronous). The behaviour after release follows AUTO_START.

## Test plan
- AUTO_START=1, slave returns ID 0 and timestamp 1582963486 with 0 wait states and latency 1 → done after 5 edges from reset release; id_ok=1, ts_ok=1, timeout=0; avm_address sequence 0 then 1.
- Slave returns ID 0x00000001 → id_value=1, id_ok=0, ts_ok=1, done=1.
- Waitrequest held high for 3 cycles on each read → avm_read and avm_address held stable throughout; done 6 edges later than the best case.
- TIMEOUT_CYCLES=8, data valid never returned for word 1 → avm_read=0 and timeout=1 at the 8th cycle; done=1, id_ok=0, ts_ok=0. A later stray data valid carrying 0xDEADBEEF leaves ts_value=0.
- start pulsed while busy, then pulsed again after done → the first pulse is ignored; the second clears all flags in one edge and reruns the sequence with the same results.
- reset_n pulsed low while in TS_WAIT → all outputs are 0 with no clock edge; a full sequence reruns after release.

Source files
------------

// File: rtl/sysid_read_master.sv
// Avalon-MM read master that fetches the system ID word and the build timestamp,
// compares both against expected values and reports pass/fail/timeout flags.
module sysid_read_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1582963486,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        auto_pend_r;
  logic [15:0] cnt_r;
  logic        limit_s;
  logic        launch_s;
  logic        cap_id_s;
  logic        cap_ts_s;
  logic        abort_s;

  logic        read_r;
  logic        addr_r;
  logic        busy_r;
  logic        done_r;
  logic        id_ok_r;
  logic        ts_ok_r;
  logic        timeout_r;
  logic [31:0] id_value_r;
  logic [31:0] ts_value_r;

  // Next-state decode; a completing event on the limit edge takes priority over the abort
  always_comb begin
    state_s  = state_r;
    launch_s = 1'b0;
    cap_id_s = 1'b0;
    cap_ts_s = 1'b0;
    abort_s  = 1'b0;
    limit_s  = (cnt_r == LIMIT);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start || auto_pend_r) begin
          state_s  = ST_ID_REQ;
          launch_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_ID_REQ: begin
        if (!avm_waitrequest) begin
          state_s = ST_ID_WAIT;
        end else if (limit_s) begin
          state_s = ST_DONE;
          abort_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_ID_WAIT: begin
        if (avm_readdatavalid) begin
          state_s  = ST_TS_REQ;
          cap_id_s = 1'b1;
        end else if (limit_s) begin
          state_s = ST_DONE;
          abort_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_TS_REQ: begin
        if (!avm_waitrequest) begin
          state_s = ST_TS_WAIT;
        end else if (limit_s) begin
          state_s = ST_DONE;
          abort_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_TS_WAIT: begin
        if (avm_readdatavalid) begin
          state_s  = ST_DONE;
          cap_ts_s = 1'b1;
        end else if (limit_s) begin
          state_s = ST_DONE;
          abort_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register; the power-up launch request lives for exactly one edge after reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      auto_pend_r <= AUTO_START;
    end else begin
      state_r     <= state_s;
      auto_pend_r <= 1'b0;
    end
  end

  // Per-transaction cycle counter, restarted whenever a request state is entered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= 16'd0;
    end else if (launch_s || cap_id_s) begin
      cnt_r <= 16'd0;
    end else if (busy_r) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered bus outputs, status flags and captured words
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_r     <= 1'b0;
      addr_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      id_ok_r    <= 1'b0;
      ts_ok_r    <= 1'b0;
      timeout_r  <= 1'b0;
      id_value_r <= 32'd0;
      ts_value_r <= 32'd0;
    end else begin
      read_r <= (state_s == ST_ID_REQ) || (state_s == ST_TS_REQ);
      addr_r <= (state_s == ST_TS_REQ) || (state_s == ST_TS_WAIT);
      busy_r <= (state_s != ST_IDLE) && (state_s != ST_DONE);
      if (launch_s) begin
        done_r     <= 1'b0;
        id_ok_r    <= 1'b0;
        ts_ok_r    <= 1'b0;
        timeout_r  <= 1'b0;
        id_value_r <= 32'd0;
        ts_value_r <= 32'd0;
      end else if (cap_id_s) begin
        id_value_r <= avm_readdata;
      end else if (cap_ts_s) begin
        ts_value_r <= avm_readdata;
        done_r     <= 1'b1;
        id_ok_r    <= (id_value_r == EXPECTED_ID);
        ts_ok_r    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end else if (abort_s) begin
        done_r    <= 1'b1;
        timeout_r <= 1'b1;
        id_ok_r   <= 1'b0;
        ts_ok_r   <= 1'b0;
      end else begin
        done_r <= done_r;
      end
    end
  end

  assign avm_read    = read_r;
  assign avm_address = addr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign id_ok       = id_ok_r;
  assign ts_ok       = ts_ok_r;
  assign timeout     = timeout_r;
  assign id_value    = id_value_r;
  assign ts_value    = ts_value_r;

endmodule

// File: tb/tb_sysid_read_master.sv
// Bench for sysid_read_master: reactive Avalon slave, timeline model of the
// expected outputs checked every cycle, plus hand-computed literal checks.
module tb_sysid_read_master;

  localparam int          T      = 8;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1582963486;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  always #5 clock = ~clock;

  sysid_read_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata), .busy(busy), .done(done), .id_ok(id_ok),
    .ts_ok(ts_ok), .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
  );

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  // slave configuration per word: wait states, latency (0 = never), data
  int          w_cfg[2];
  int          l_cfg[2];
  logic [31:0] d_cfg[2];
  int          wcount = 0;
  bit          pend = 1'b0;
  int          pend_cd = 0;
  logic [31:0] pend_data = 32'd0;
  bit          last_read = 1'b0;
  bit          last_wr = 1'b0;
  bit          last_addr = 1'b0;
  bit          stray = 1'b0;

  // model: snapshot of the running sequence and the edge on which it started
  int          sw[2];
  int          sl[2];
  logic [31:0] sd[2];
  int          s_edge = 0;
  int          done_edge = -1;
  int          acc_addr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int phase_cycles(input int w, input int l);
    return (l == 0) ? 100000 : w + 1 + l;
  endfunction

  // A phase takes w+1+l cycles from request entry; it completes iff that fits in T
  task automatic timeline(output int c0, output bit ok0, output bit ok1, output int tdone);
    int c1;
    c0  = phase_cycles(sw[0], sl[0]);
    c1  = phase_cycles(sw[1], sl[1]);
    ok0 = (c0 <= T);
    ok1 = ok0 && (c1 <= T);
    tdone = !ok0 ? T : (ok1 ? c0 + c1 : c0 + T);
  endtask

  task automatic model_check();
    int r, c0, tdone, rq0, rq1;
    bit ok0, ok1, e_read, e_busy;
    logic [31:0] e_id, e_ts;
    timeline(c0, ok0, ok1, tdone);
    r   = edge_n - s_edge;
    rq0 = (sw[0] + 1 < T) ? sw[0] + 1 : T;
    rq1 = (sw[1] + 1 < T) ? sw[1] + 1 : T;
    e_read = (r < rq0) || (ok0 && r >= c0 && r - c0 < rq1);
    e_busy = (r < tdone);
    e_id   = (ok0 && r >= c0) ? sd[0] : 32'd0;
    e_ts   = (!e_busy && ok1) ? sd[1] : 32'd0;
    chk("avm_read", avm_read, e_read);
    if (e_read) chk("avm_address", avm_address, (ok0 && r >= c0));
    chk("busy", busy, e_busy);
    chk("done", done, !e_busy);
    chk("timeout", timeout, !e_busy && !ok1);
    chk("id_value", id_value, e_id);
    chk("ts_value", ts_value, e_ts);
    chk("id_ok", id_ok, !e_busy && ok1 && (sd[0] == EXP_ID));
    chk("ts_ok", ts_ok, !e_busy && ok1 && (sd[1] == EXP_TS));
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      sw[i] = w_cfg[i]; sl[i] = l_cfg[i]; sd[i] = d_cfg[i];
    end
    done_edge = -1;
    acc_addr_q.delete();
  endtask

  task automatic cycle();
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    if (last_read && !last_wr) begin
      acc_addr_q.push_back(int'(last_addr));
      if (l_cfg[last_addr] != 0) begin
        pend = 1'b1; pend_cd = l_cfg[last_addr]; pend_data = d_cfg[last_addr];
      end
    end
    if (done === 1'b1 && done_edge < 0) done_edge = edge_n;
    model_check();
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'hA5A5_0000 ^ 32'(edge_n);
    if (pend) begin
      pend_cd--;
      if (pend_cd == 0) begin
        pend = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = pend_data;
      end
    end
    if (stray) begin
      stray = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF;
    end
    if (avm_read) begin
      if (wcount < w_cfg[avm_address]) begin
        avm_waitrequest = 1'b1; wcount++;
      end else begin
        avm_waitrequest = 1'b0;
      end
    end else begin
      wcount = 0; avm_waitrequest = 1'b0;
    end
    last_read = avm_read; last_wr = avm_waitrequest; last_addr = avm_address;
  endtask

  task automatic set_cfg(input int w0, input int l0, input logic [31:0] d0,
                         input int w1, input int l1, input logic [31:0] d1);
    w_cfg[0] = w0; l_cfg[0] = l0; d_cfg[0] = d0;
    w_cfg[1] = w1; l_cfg[1] = l1; d_cfg[1] = d1;
  endtask

  task automatic pulse_start();
    int c0, tdone;
    bit ok0, ok1;
    timeline(c0, ok0, ok1, tdone);
    start = 1'b1;
    if (edge_n - s_edge >= tdone) begin
      snap();
      s_edge = edge_n + 1;
    end
    cycle();
    start = 1'b0;
  endtask

  task automatic run_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_done_reached"}, 32'(got), 32'd1);
  endtask

  // Called just after a falling edge; outputs must clear with no clock edge
  task automatic apply_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_read", avm_read, 1'b0);
    chk("rst_address", avm_address, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {id_ok, ts_ok, timeout}, 3'b000);
    chk("rst_id_value", id_value, 32'd0);
    chk("rst_ts_value", ts_value, 32'd0);
    pend = 1'b0; wcount = 0; stray = 1'b0;
    last_read = 1'b0; last_wr = 1'b0; last_addr = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    #1 reset_n = 1'b1;
    snap();
    s_edge = edge_n + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // best case after reset: 0 wait states, latency 1
    set_cfg(0, 1, 32'd0, 0, 1, EXP_TS);
    @(negedge clock);
    apply_reset();
    run_done("best");
    chk("best_latency", done_edge - s_edge + 1, 5);
    chk("best_flags", {id_ok, ts_ok, timeout}, 3'b110);
    chk("best_n_accepts", acc_addr_q.size(), 2);
    if (acc_addr_q.size() == 2) begin
      chk("best_addr0", acc_addr_q[0], 0);
      chk("best_addr1", acc_addr_q[1], 1);
    end
    repeat (2) cycle();

    // wrong ID word
    set_cfg(0, 1, 32'h0000_0001, 0, 1, EXP_TS);
    pulse_start();
    run_done("badid");
    chk("badid_value", id_value, 32'd1);
    chk("badid_flags", {id_ok, ts_ok, done}, 3'b011);
    repeat (2) cycle();

    // three wait states on each read
    set_cfg(3, 1, 32'd0, 3, 1, EXP_TS);
    pulse_start();
    run_done("wait3");
    chk("wait3_latency", done_edge - s_edge + 1, 11);
    repeat (2) cycle();

    // start while busy is ignored, restart after done clears everything in one edge
    set_cfg(0, 1, 32'd0, 0, 1, EXP_TS);
    pulse_start();
    cycle();
    pulse_start();
    run_done("busystart");
    chk("busystart_latency", done_edge - s_edge + 1, 5);
    cycle();
    pulse_start();
    chk("restart_cleared", {done, id_ok, ts_ok, timeout}, 4'b0000);
    chk("restart_ts_value", ts_value, 32'd0);
    run_done("restart");
    chk("restart_flags", {id_ok, ts_ok, timeout}, 3'b110);
    repeat (2) cycle();

    // data valid on the limit edge wins
    set_cfg(0, 7, 32'd0, 0, 1, EXP_TS);
    pulse_start();
    run_done("edge_win");
    chk("edge_win_flags", {id_ok, ts_ok, timeout}, 3'b110);
    repeat (2) cycle();

    // waitrequest never released within the limit: abort in the request phase
    set_cfg(8, 1, 32'd0, 0, 1, EXP_TS);
    pulse_start();
    run_done("req_abort");
    chk("req_abort_latency", done_edge - s_edge + 1, 9);
    chk("req_abort_flags", {id_ok, ts_ok, timeout}, 3'b001);
    repeat (3) cycle();

    // data one cycle too late: abort, then the late beat lands in DONE
    set_cfg(0, 8, 32'h0000_0001, 0, 1, EXP_TS);
    pulse_start();
    run_done("late_abort");
    repeat (4) cycle();
    chk("late_abort_id_value", id_value, 32'd0);
    chk("late_abort_timeout", timeout, 1'b1);

    // timestamp never returned, then a stray beat
    set_cfg(0, 1, 32'd0, 0, 0, EXP_TS);
    pulse_start();
    run_done("ts_abort");
    chk("ts_abort_latency", done_edge - s_edge + 1, 11);
    chk("ts_abort_flags", {id_ok, ts_ok, timeout, avm_read}, 4'b0010);
    stray = 1'b1;
    repeat (3) cycle();
    chk("stray_ts_value", ts_value, 32'd0);

    // reset while in TS_WAIT, then a full rerun
    set_cfg(0, 1, 32'd0, 0, 6, EXP_TS);
    pulse_start();
    repeat (3) cycle();
    chk("pre_reset_busy", {busy, avm_read}, 2'b10);
    set_cfg(0, 1, 32'd0, 0, 1, EXP_TS);
    apply_reset();
    run_done("after_reset");
    chk("after_reset_latency", done_edge - s_edge + 1, 5);
    chk("after_reset_flags", {id_ok, ts_ok, timeout}, 3'b110);
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
